// File: rtl/reg_dec_rate_bridge.sv
// ---------------------------------------------------------------------------
// reg_dec_rate_bridge
//
// Register-access bridge between a full-rate register master and a slave
// register bus that runs at a decimated rate. One read or write is accepted
// at a time on the fast side and replayed on the slow side. All slow-side
// activity happens only on clk cycles qualified by the clk_2 strobe, so the
// slow bus sees every level for whole slow cycles.
//
// Ports:
//   clk              system clock (only clock)
//   rst              asynchronous active-high reset
//   clk_2            decimated-rate strobe, high one clk cycle per slow cycle
//   reg_s_addr       fast-side address
//   reg_s_rd         fast-side read request, held until ready
//   reg_s_wr         fast-side write request, held until ready (wins over rd)
//   reg_s_ready      one-cycle completion pulse (registered)
//   reg_s_writedata  fast-side write data
//   reg_s_readdata   read result, held until the next read completes
//   reg_m_addr       slow-side address, holds its last value when idle
//   reg_m_rd         slow-side read request
//   reg_m_wr         slow-side write request
//   reg_m_ready      slow-side completion, meaningful only when clk_2=1
//   reg_m_writedata  slow-side write data, holds its last value when idle
//   reg_m_readdata   slow-side read data, valid with reg_m_ready
// ---------------------------------------------------------------------------
module reg_dec_rate_bridge #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_2,
    input  logic [AW-1:0] reg_s_addr,
    input  logic          reg_s_rd,
    input  logic          reg_s_wr,
    output logic          reg_s_ready,
    input  logic [31:0]   reg_s_writedata,
    output logic [31:0]   reg_s_readdata,
    output logic [AW-1:0] reg_m_addr,
    output logic          reg_m_rd,
    output logic          reg_m_wr,
    input  logic          reg_m_ready,
    output logic [31:0]   reg_m_writedata,
    input  logic [31:0]   reg_m_readdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic          op_wr;    // latched op kind: 1 = write, 0 = read
    logic [AW-1:0] addr_q;   // latched request, kept apart from reg_m_* so
    logic [31:0]   wdata_q;  // the slow bus only sees it on a clk_2 edge

    // NOTE: every register here is written with non-blocking assignments so
    // all state updates see the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            op_wr           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            reg_s_ready     <= 1'b0;
            reg_s_readdata  <= '0;
            reg_m_addr      <= '0;
            reg_m_rd        <= 1'b0;
            reg_m_wr        <= 1'b0;
            reg_m_writedata <= '0;
        end else begin
            // Ready is a pulse: only the WAIT->DONE transition raises it,
            // so it can never be high for two consecutive cycles.
            reg_s_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (reg_s_wr || reg_s_rd) begin
                        op_wr   <= reg_s_wr;  // write wins when both are high
                        addr_q  <= reg_s_addr;
                        wdata_q <= reg_s_writedata;
                        state   <= ISSUE;
                    end
                end

                // Issue is deferred to the first strobe seen in ISSUE, so a
                // strobe coinciding with the latch cycle is never used.
                ISSUE: begin
                    if (clk_2) begin
                        reg_m_addr      <= addr_q;
                        reg_m_writedata <= wdata_q;
                        reg_m_wr        <= op_wr;
                        reg_m_rd        <= ~op_wr;
                        state           <= WAIT;
                    end
                end

                // reg_m_ready only counts on strobe cycles; the request is
                // dropped on that same strobe edge.
                WAIT: begin
                    if (clk_2 && reg_m_ready) begin
                        if (reg_m_rd) begin
                            reg_s_readdata <= reg_m_readdata;
                        end
                        reg_m_rd    <= 1'b0;
                        reg_m_wr    <= 1'b0;
                        reg_s_ready <= 1'b1;
                        state       <= DONE;
                    end
                end

                // One ready cycle; the master drops its request on the edge
                // that ends it, so IDLE does not re-trigger.
                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dec_rate_bridge.sv
// ---------------------------------------------------------------------------
// tb_reg_dec_rate_bridge
//
// Self-checking bench for reg_dec_rate_bridge. Directed records in a table
// plus randomized transactions, all checked against a transaction-level
// model: the expected issue and completion cycles are derived from the
// clk_2 schedule with plain arithmetic, and the expected read data is the
// value the emulated slave returned for the most recent read.
// ---------------------------------------------------------------------------
module tb_reg_dec_rate_bridge;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_2;
    logic [AW-1:0] reg_s_addr;
    logic          reg_s_rd;
    logic          reg_s_wr;
    logic          reg_s_ready;
    logic [31:0]   reg_s_writedata;
    logic [31:0]   reg_s_readdata;
    logic [AW-1:0] reg_m_addr;
    logic          reg_m_rd;
    logic          reg_m_wr;
    logic          reg_m_ready;
    logic [31:0]   reg_m_writedata;
    logic [31:0]   reg_m_readdata;

    reg_dec_rate_bridge #(.AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_2           (clk_2),
        .reg_s_addr      (reg_s_addr),
        .reg_s_rd        (reg_s_rd),
        .reg_s_wr        (reg_s_wr),
        .reg_s_ready     (reg_s_ready),
        .reg_s_writedata (reg_s_writedata),
        .reg_s_readdata  (reg_s_readdata),
        .reg_m_addr      (reg_m_addr),
        .reg_m_rd        (reg_m_rd),
        .reg_m_wr        (reg_m_wr),
        .reg_m_ready     (reg_m_ready),
        .reg_m_writedata (reg_m_writedata),
        .reg_m_readdata  (reg_m_readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   sdata;      // value the slave returns on a read
        int            period;     // clk_2 high when cycle % period == 0
        int            delay;      // slow cycles until the slave answers
        bit            noise;      // random reg_m_ready on clk_2=0 cycles
        int            settle;     // idle cycles checked afterwards
        logic [31:0]   exp_rdata;  // reg_s_readdata expected after the op
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle bookkeeping and slave emulation state.
    int          cyc_n     = 0;
    int          period    = 1;
    int          sdelay    = 1;
    bit          noise     = 1'b0;
    logic [31:0] sdata     = '0;
    int          slow_cnt  = 0;
    int          ready_cnt = 0;
    bit          prev_c2   = 1'b0;
    bit          prev_rdy  = 1'b0;
    bit          rst_prev  = 1'b1;
    bit          exp_rdy_next = 1'b0;
    logic [1:0]  prev_m    = 2'b00;

    // Reference model state.
    logic [31:0]   exp_rdata = '0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // First cycle >= from on which clk_2 is high.
    function automatic int next_c2(input int from);
        int c = from;
        while ((c % period) != 0) c++;
        return c;
    endfunction

    // Advance one clk cycle. Outputs are sampled 1 ns after the edge; the
    // global rules are checked, then clk_2 and the slave response for the
    // new cycle are driven.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
        if (!rst && !rst_prev) begin
            check("ready_timing", {31'd0, reg_s_ready}, {31'd0, exp_rdy_next});
            if ({reg_m_rd, reg_m_wr} != prev_m)
                check("m_req_change_on_clk2", {31'd0, prev_c2}, 32'd1);
            if (reg_s_ready)
                check("ready_not_double", {31'd0, prev_rdy}, 32'd0);
        end
        if (reg_s_ready) ready_cnt++;
        prev_rdy = reg_s_ready;
        prev_m   = {reg_m_rd, reg_m_wr};
        rst_prev = rst;

        clk_2 = ((cyc_n % period) == 0);
        if (reg_m_rd || reg_m_wr) begin
            if (clk_2) slow_cnt++;
        end else begin
            slow_cnt = 0;
        end
        if (clk_2) reg_m_ready = (reg_m_rd || reg_m_wr) && (slow_cnt >= sdelay);
        else       reg_m_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        reg_m_readdata = (clk_2 && reg_m_ready) ? sdata : $urandom;
        exp_rdy_next = clk_2 && reg_m_ready && (reg_m_rd || reg_m_wr);
        prev_c2 = clk_2;
    endtask

    // One full fast-side transaction. The request is first presented in the
    // cycle after the call's first tick (an IDLE cycle) and dropped as soon
    // as the ready pulse is observed.
    task automatic do_txn(input vec_t v);
        int         t0, ie, c, exp_ready_cyc;
        logic [1:0] exp_m;
        bit         seen, stab_bad, done;

        period = v.period;
        sdelay = v.delay;
        noise  = v.noise;
        sdata  = v.sdata;
        tick();
        reg_s_rd        = v.rd;
        reg_s_wr        = v.wr;
        reg_s_addr      = v.addr;
        reg_s_writedata = v.wdata;

        t0 = cyc_n;
        ie = next_c2(t0 + 1);               // edge that issues the request
        c  = next_c2(ie + 1);               // first strobe the slave sees
        for (int k = 1; k < v.delay; k++) c = next_c2(c + 1);
        exp_ready_cyc = c + 1;
        exp_m = v.wr ? 2'b01 : 2'b10;

        seen = 1'b0; stab_bad = 1'b0; done = 1'b0; ready_cnt = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            // Later changes to the request fields must be ignored.
            reg_s_addr      = AW'($urandom);
            reg_s_writedata = $urandom;
            if (reg_m_rd || reg_m_wr) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("issue_cycle", cyc_n, ie + 1);
                    check("m_kind", {30'd0, reg_m_rd, reg_m_wr}, {30'd0, exp_m});
                    check("m_addr", {18'd0, reg_m_addr}, {18'd0, v.addr});
                    check("m_wdata", reg_m_writedata, v.wdata);
                end else if ({reg_m_rd, reg_m_wr} != exp_m || reg_m_addr != v.addr ||
                             reg_m_writedata != v.wdata) begin
                    stab_bad = 1'b1;
                end
            end
            if (reg_s_ready) begin
                done = 1'b1;
                check("ready_cycle", cyc_n, exp_ready_cyc);
                reg_s_rd = 1'b0;
                reg_s_wr = 1'b0;
            end
        end
        if (!done) begin
            check("ready_timeout", 32'd0, 32'd1);
            reg_s_rd = 1'b0;
            reg_s_wr = 1'b0;
        end
        check("m_issued", {31'd0, seen}, 32'd1);
        check("m_stable", {31'd0, stab_bad}, 32'd0);
        check("m_req_dropped", {30'd0, reg_m_rd, reg_m_wr}, 32'd0);
        check("ready_once", ready_cnt, 32'd1);

        if (v.rd && !v.wr) exp_rdata = v.sdata;
        last_addr  = v.addr;
        last_wdata = v.wdata;
        check("rdata", reg_s_readdata, v.exp_rdata);
    endtask

    // Idle cycles after a transaction: no new activity, outputs held.
    task automatic settle(input int n);
        ready_cnt = 0;
        repeat (n) tick();
        check("no_extra_ready", ready_cnt, 32'd0);
        check("idle_m_req", {30'd0, reg_m_rd, reg_m_wr}, 32'd0);
        check("rdata_hold", reg_s_readdata, exp_rdata);
        check("m_addr_hold", {18'd0, reg_m_addr}, {18'd0, last_addr});
        check("m_wdata_hold", reg_m_writedata, last_wdata);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        clk_2           = 1'b0;
        reg_s_addr      = '0;
        reg_s_rd        = 1'b0;
        reg_s_wr        = 1'b0;
        reg_s_writedata = '0;
        reg_m_ready     = 1'b0;
        reg_m_readdata  = '0;

        //        rd    wr    addr      wdata         sdata         per dly noise settle exp_rdata
        tbl[0] = '{1'b0, 1'b1, 14'h0123, 32'hDEADBEEF, 32'h00000000, 4, 2, 1'b0, 3, 32'h00000000};
        tbl[1] = '{1'b1, 1'b0, 14'h3FFF, 32'h00000000, 32'h12345678, 4, 1, 1'b0, 2, 32'h12345678};
        tbl[2] = '{1'b1, 1'b0, 14'h0042, 32'h5555AAAA, 32'hA5A55A5A, 3, 2, 1'b1, 2, 32'hA5A55A5A};
        tbl[3] = '{1'b1, 1'b0, 14'h0010, 32'h00000000, 32'hCAFEF00D, 1, 1, 1'b0, 0, 32'hCAFEF00D};
        tbl[4] = '{1'b0, 1'b1, 14'h0011, 32'h11112222, 32'h77777777, 2, 1, 1'b1, 3, 32'hCAFEF00D};
        tbl[5] = '{1'b1, 1'b1, 14'h2000, 32'h0BADF00D, 32'hFFFFFFFF, 1, 3, 1'b0, 2, 32'hCAFEF00D};

        // Reset state.
        repeat (3) tick();
        check("rst_s_ready", {31'd0, reg_s_ready}, 32'd0);
        check("rst_s_rdata", reg_s_readdata, 32'd0);
        check("rst_m_req", {30'd0, reg_m_rd, reg_m_wr}, 32'd0);
        check("rst_m_addr", {18'd0, reg_m_addr}, 32'd0);
        check("rst_m_wdata", reg_m_writedata, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Directed table (entry 3 followed directly by 4 is back-to-back).
        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i]);
            if (tbl[i].settle > 0) settle(tbl[i].settle);
        end

        // Reset while the slow side is still waiting on a read.
        period = 4; sdelay = 5; noise = 1'b0; sdata = 32'h0BEEF0BE;
        tick();
        reg_s_rd   = 1'b1;
        reg_s_addr = 14'h0155;
        for (int i = 0; i < 40 && !reg_m_rd; i++) tick();
        check("rst_seq_reached_wait", {31'd0, reg_m_rd}, 32'd1);
        tick();
        #3 rst = 1'b1;
        #1;
        check("rst_async_m_rd", {31'd0, reg_m_rd}, 32'd0);
        check("rst_async_ready", {31'd0, reg_s_ready}, 32'd0);
        check("rst_async_rdata", reg_s_readdata, 32'd0);
        exp_rdata  = '0;
        last_addr  = '0;
        last_wdata = '0;
        reg_s_rd   = 1'b0;
        ready_cnt  = 0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (8) tick();
        check("rst_no_ready", ready_cnt, 32'd0);
        check("rst_m_idle", {30'd0, reg_m_rd, reg_m_wr}, 32'd0);
        rv = '{1'b1, 1'b0, 14'h0155, 32'h0, 32'h600DCAFE, 2, 2, 1'b1, 2, 32'h600DCAFE};
        do_txn(rv);
        settle(rv.settle);

        // Randomized transactions against the model.
        for (int n = 0; n < 20; n++) begin
            int k;
            k = $urandom_range(0, 2);
            rv.rd     = (k != 1);
            rv.wr     = (k != 0);
            rv.addr   = AW'($urandom);
            rv.wdata  = $urandom;
            rv.sdata  = $urandom;
            rv.period = $urandom_range(1, 5);
            rv.delay  = $urandom_range(1, 3);
            rv.noise  = 1'($urandom_range(0, 1));
            rv.settle = $urandom_range(0, 2);
            rv.exp_rdata = (rv.rd && !rv.wr) ? rv.sdata : exp_rdata;
            do_txn(rv);
            if (rv.settle > 0) settle(rv.settle);
        end
        settle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dec_rate_bridge.md
Name: reg_dec_rate_bridge

Overview:
- Register-access rate-decimation bridge between a full-rate register master (the command executor) and a slave-side register bus that runs at a decimated rate.
- Accepts one read or write request at a time on the fast side and replays it on the slow side. All slow-side activity happens only on `clk` cycles qualified by the `clk_2` strobe.
- Completes the fast-side handshake with a single-cycle ready pulse; read data stays held afterwards.

Parameters:
- AW, 14, register address width.

Ports:
- clk  in  1  system clock (only clock).
- rst  in  1  reset, asynchronous, active-high.
- clk_2  in  1  decimated-rate strobe; high for one clk cycle per slow-bus cycle.
- reg_s_addr  in  AW  fast-side address.
- reg_s_rd  in  1  fast-side read request, held until ready.
- reg_s_wr  in  1  fast-side write request, held until ready.
- reg_s_ready  out  1  one-cycle completion pulse.
- reg_s_writedata  in  32  fast-side write data.
- reg_s_readdata  out  32  read result, held.
- reg_m_addr  out  AW  slow-side address.
- reg_m_rd  out  1  slow-side read request.
- reg_m_wr  out  1  slow-side write request.
- reg_m_ready  in  1  slow-side completion, valid only when clk_2=1.
- reg_m_writedata  out  32  slow-side write data.
- reg_m_readdata  in  32  slow-side read data, valid with reg_m_ready.

Behaviour:
- Reset: all outputs 0; FSM to IDLE. Reset asynchronous on assert; release synchronous to clk.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If reg_s_wr or reg_s_rd is high: latch reg_s_addr, reg_s_writedata and op kind; go to ISSUE.
  - If both are high, write wins.
- ISSUE:
  - On the first clk edge with clk_2=1: drive reg_m_addr and reg_m_writedata from the latches, assert reg_m_wr or reg_m_rd, go to WAIT.
  - If clk_2=1 in the same cycle the request is latched, issue happens on the next clk_2 cycle, not the same one.
- WAIT:
  - reg_m_* outputs stay stable.
  - On a clk edge with clk_2=1 and reg_m_ready=1:
    - deassert reg_m_rd/reg_m_wr;
    - for a read, capture reg_m_readdata into reg_s_readdata;
    - go to DONE.
  - reg_m_ready is ignored when clk_2=0.
- DONE: reg_s_ready=1 for exactly this one cycle; next state IDLE unconditionally.
- Request lifetime:
  - The fast master must drop rd/wr on the edge ending the ready cycle, so IDLE does not re-trigger.
  - A request still high in IDLE is a new transaction.
- Output timing:
  - reg_m_rd/reg_m_wr change only on clk_2 cycles, so the slow side sees each level for whole slow cycles.
  - reg_m_addr/writedata hold their last values when idle.
- reg_s_readdata:
  - Updated only on read completion.
  - Held until the next read completes; writes do not alter it.
  - Both 16-bit halves remain readable on cycles after the ready pulse.
- reg_s_ready: registered output; never high for two consecutive cycles.
- Minimum latency: request seen at cycle 0 with clk_2 high every cycle and reg_m_ready immediate gives
  - reg_m_rd at cycle 2;
  - completion sampled at cycle 2;
  - reg_s_ready at cycle 3.
- Reset mid-transaction: aborts; reg_m_rd/wr and reg_s_ready drop to 0 immediately; no ready pulse is produced.
- Request inputs changing during ISSUE/WAIT/DONE are ignored (the latched values are used).

Test Plan:
- Write: addr=0x0123, data=0xDEADBEEF, clk_2 every 4th cycle, m_ready returned 2 slow cycles later -> reg_m_wr=1 with addr 0x0123 / data 0xDEADBEEF, held stable across clk_2 samples; exactly one reg_s_ready pulse; reg_s_readdata unchanged.
- Read: addr=0x3FFF, slow side returns 0x12345678 -> reg_m_rd asserted only on a clk_2 edge; reg_s_ready pulses once; reg_s_readdata=0x12345678 and still held 2 cycles after the pulse.
- m_ready high while clk_2=0 -> ignored; completion occurs only at the next clk_2=1 cycle with m_ready=1.
- Back-to-back: read then write, master drops rd on the cycle after ready -> no duplicate transaction; second op completes; readdata keeps the first value.
- rd and wr both high -> write performed; reg_m_rd stays 0.
- Assert rst during WAIT -> reg_m_rd/wr=0 at once; no reg_s_ready; the next request after release operates normally.
